apb_master_seq: RTL and testbench

APB_MASTER_SEQ -- requirements
Module: apb_master_seq

---
 rtl/apb_master_seq.sv | 150 +++++++++++++++
 tb/tb_apb_master_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_seq.sv
// APB master sequencer: queues {write, addr, wdata} commands in a FIFO and replays them as APB transfers.
// Define APB_TIMEOUT_EN to build the ACCESS-phase timeout abort (TIMEOUT_CYCLES wait limit).
module apb_master_seq #(
   parameter int CMD_DEPTH      = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic       PCLK,
   input  logic       PRESET,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       rsp_error,
   output logic       PSELx,
   output logic       PENABLE,
   output logic       PWRITE,
   output logic [6:0] PADDR,
   output logic [7:0] PWDATA,
   input  logic       PREADY,
   input  logic [7:0] PRDATA
);
   localparam int AW = $clog2(CMD_DEPTH);
   localparam int EW = 16;

   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

   state_t        state_r;
   logic [EW-1:0] fifo_mem_r [CMD_DEPTH];
   logic [AW:0]   wr_ptr_r;
   logic [AW:0]   rd_ptr_r;
   logic          full_s;
   logic          empty_s;
   logic          push_s;
   logic          pop_s;
   logic [EW-1:0] head_s;

   if ((CMD_DEPTH < 2) || (CMD_DEPTH > 16) || ((CMD_DEPTH & (CMD_DEPTH - 1)) != 0) ||
       (TIMEOUT_CYCLES < 1)) begin : g_param_check
      $error("apb_master_seq: CMD_DEPTH must be a power of two in 2..16 and TIMEOUT_CYCLES >= 1");
   end

`ifdef APB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic          rsp_error_r;
   logic [TW-1:0] tmo_cnt_r;
   assign rsp_error = rsp_error_r;
`else
   assign rsp_error = 1'b0;
`endif

   // FIFO status from the pointers only, so cmd_ready never depends on cmd_valid
   always_comb begin
      empty_s   = (wr_ptr_r == rd_ptr_r);
      full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
      cmd_ready = !full_s;
      push_s    = cmd_valid && !full_s;
      pop_s     = (state_r == IDLE) && !empty_s;
      head_s    = fifo_mem_r[rd_ptr_r[AW-1:0]];
   end

   // Command storage; contents are don't-care while the pointers say empty
   always_ff @(posedge PCLK) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r[AW-1:0]] <= {cmd_write, cmd_addr, cmd_wdata};
      end
   end

   // FIFO pointers carry one extra MSB to tell full from empty
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
         end
      end
   end

   // APB transfer sequencer with registered bus and response outputs
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_r   <= IDLE;
         PSELx     <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= 7'h00;
         PWDATA    <= 8'h00;
         rsp_valid <= 1'b0;
         rsp_rdata <= 8'h00;
`ifdef APB_TIMEOUT_EN
         rsp_error_r <= 1'b0;
         tmo_cnt_r   <= {TW{1'b0}};
`endif
      end else begin
         rsp_valid <= 1'b0;
         case (state_r)
            IDLE: begin
               if (pop_s) begin
                  PWRITE  <= head_s[15];
                  PADDR   <= head_s[14:8];
                  PWDATA  <= head_s[7:0];
                  PSELx   <= 1'b1;
                  PENABLE <= 1'b0;
                  state_r <= SETUP;
               end
            end
            SETUP: begin
               PENABLE <= 1'b1;
               state_r <= ACCESS;
            end
            ACCESS: begin
               if (PREADY) begin
                  PSELx     <= 1'b0;
                  PENABLE   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= PWRITE ? 8'h00 : PRDATA;
                  state_r   <= IDLE;
`ifdef APB_TIMEOUT_EN
                  rsp_error_r <= 1'b0;
                  tmo_cnt_r   <= {TW{1'b0}};
               end else if (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
                  // This stalled cycle is the TIMEOUT_CYCLES-th one: abandon the slave
                  PSELx       <= 1'b0;
                  PENABLE     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_rdata   <= 8'h00;
                  rsp_error_r <= 1'b1;
                  tmo_cnt_r   <= {TW{1'b0}};
                  state_r     <= IDLE;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + TW'(1);
`endif
               end
            end
            default: begin
               PSELx   <= 1'b0;
               PENABLE <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_apb_master_seq.sv
// Self-checking bench for apb_master_seq: scoreboard of expected responses plus per-scenario bus checks.
module tb_apb_master_seq;
   logic       PCLK = 1'b0;
   logic       PRESET;
   logic       cmd_valid, cmd_ready, cmd_write;
   logic [6:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid, rsp_error;
   logic [7:0] rsp_rdata;
   logic       PSELx, PENABLE, PWRITE, PREADY;
   logic [6:0] PADDR;
   logic [7:0] PWDATA, PRDATA;

   logic [8:0] exp_q [$];
   logic [8:0] mon_exp;
   int         n_cmp = 0;
   int         n_err = 0;
   logic       stall = 1'b0;
   int         wait_states = 0;
   int         acc_cyc = 0;

   apb_master_seq dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
      .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PREADY(PREADY), .PRDATA(PRDATA)
   );

   always #5 PCLK = ~PCLK;

   function automatic logic [7:0] slave_data(input logic [6:0] a);
      return (a == 7'h02) ? 8'hA5 : ({1'b0, a} ^ 8'h3C);
   endfunction

   // Slave model: inserts wait_states low cycles at the start of each ACCESS phase
   assign PRDATA = slave_data(PADDR);
   assign PREADY = !stall && (acc_cyc >= wait_states);
   always @(posedge PCLK) acc_cyc <= (PSELx && PENABLE) ? acc_cyc + 1 : 0;

   // Scoreboard pop side
   always @(negedge PCLK) begin
      if (rsp_valid) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL rsp_unexpected: got rsp_valid err=%0b rdata=%02h, required no response", rsp_error, rsp_rdata);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({rsp_error, rsp_rdata} !== mon_exp) begin
               n_err++;
               $display("FAIL rsp_data: got err=%0b rdata=%02h, required err=%0b rdata=%02h",
                        rsp_error, rsp_rdata, mon_exp[8], mon_exp[7:0]);
            end
         end
      end
   end

   task automatic push_cmd(input logic w, input logic [6:0] a, input logic [7:0] d, input logic e);
      int t = 0;
      @(negedge PCLK);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      while (cmd_ready !== 1'b1 && t < 200) begin
         @(negedge PCLK);
         t++;
      end
      if (t >= 200) begin
         n_cmp++; n_err++;
         $display("FAIL push_timeout: got cmd_ready=%0b for 200 cycles, required 1", cmd_ready);
         cmd_valid = 1'b0;
      end else begin
         @(posedge PCLK);
         exp_q.push_back(e ? 9'h100 : {1'b0, (w ? 8'h00 : slave_data(a))});
         #1 cmd_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 300) begin
         @(negedge PCLK);
         t++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d responses outstanding, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      PRESET = 1'b1;
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      n_cmp++;
      if ({PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_error} !== 28'h0) begin
         n_err++;
         $display("FAIL reset_outputs: got sel=%0b en=%0b wr=%0b addr=%02h wdata=%02h rv=%0b rdata=%02h err=%0b, required all 0",
                  PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_error);
      end
      PRESET = 1'b0;
      @(negedge PCLK);
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_ready: got cmd_ready=%0b, required 1", cmd_ready);
      end
   endtask

   task automatic test_write_basic();
      int sel_n = 0, en_n = 0, first_sel = -1, rsp_at = -1;
      wait_states = 0; stall = 1'b0;
      push_cmd(1'b1, 7'h0F, 8'h01, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         @(negedge PCLK);
         if (PSELx) begin
            sel_n++;
            if (first_sel < 0) first_sel = i;
            n_cmp++;
            if ({PWRITE, PADDR, PWDATA} !== {1'b1, 7'h0F, 8'h01}) begin
               n_err++;
               $display("FAIL wr_fields: got wr=%0b addr=%02h wdata=%02h, required 1 0f 01", PWRITE, PADDR, PWDATA);
            end
         end
         if (PENABLE) en_n++;
         if (rsp_valid && rsp_at < 0) rsp_at = i;
      end
      n_cmp++;
      if (sel_n !== 2) begin n_err++; $display("FAIL wr_psel_len: got %0d, required 2", sel_n); end
      n_cmp++;
      if (en_n !== 1) begin n_err++; $display("FAIL wr_penable_len: got %0d, required 1", en_n); end
      // SETUP, ACCESS, then the response cycle: three cycles counted from the pop
      n_cmp++;
      if (rsp_at - first_sel !== 2) begin
         n_err++;
         $display("FAIL wr_latency: got rsp %0d cycles after SETUP, required 2", rsp_at - first_sel);
      end
      drain();
   endtask

   task automatic test_read_wait();
      int sel_n = 0, en_n = 0, first_sel = -1, rsp_at = -1;
      wait_states = 3; stall = 1'b0;
      push_cmd(1'b0, 7'h02, 8'h77, 1'b0);
      for (int i = 1; i <= 15; i++) begin
         @(negedge PCLK);
         if (PSELx) begin
            sel_n++;
            if (first_sel < 0) first_sel = i;
            n_cmp++;
            if ({PWRITE, PADDR} !== {1'b0, 7'h02}) begin
               n_err++;
               $display("FAIL rd_fields: got wr=%0b addr=%02h, required 0 02", PWRITE, PADDR);
            end
         end
         if (PENABLE) en_n++;
         if (rsp_valid && rsp_at < 0) rsp_at = i;
      end
      n_cmp++;
      if (en_n !== 4) begin n_err++; $display("FAIL rd_access_len: got %0d, required 4", en_n); end
      n_cmp++;
      if (rsp_at - first_sel !== 5) begin
         n_err++;
         $display("FAIL rd_latency: got rsp %0d cycles after SETUP, required 5", rsp_at - first_sel);
      end
      n_cmp++;
      if (rsp_rdata !== 8'hA5) begin
         n_err++;
         $display("FAIL rd_hold: got rsp_rdata=%02h later, required a5", rsp_rdata);
      end
      wait_states = 0;
      drain();
   endtask

   task automatic test_back_to_back();
      int gap = 0, n_rise = 0;
      logic seen = 1'b0;
      wait_states = 0; stall = 1'b0;
      push_cmd(1'b1, 7'h10, 8'h33, 1'b0);
      push_cmd(1'b0, 7'h05, 8'h00, 1'b0);
      push_cmd(1'b0, 7'h7F, 8'h00, 1'b0);
      for (int i = 0; i < 20; i++) begin
         @(negedge PCLK);
         if (PSELx) begin
            if (seen && gap > 0) begin
               n_rise++;
               n_cmp++;
               if (gap !== 1) begin n_err++; $display("FAIL b2b_gap: got %0d idle cycles, required 1", gap); end
            end
            seen = 1'b1;
            gap = 0;
         end else if (seen) begin
            gap++;
         end
      end
      n_cmp++;
      if (n_rise !== 2) begin n_err++; $display("FAIL b2b_transfers: got %0d separated transfers, required 2", n_rise); end
      drain();
   endtask

   task automatic test_fifo_full();
      logic bad = 1'b0;
      wait_states = 0; stall = 1'b1;
      push_cmd(1'b0, 7'h21, 8'h00, 1'b0);
      repeat (2) @(negedge PCLK);
      for (int k = 0; k < 4; k++) push_cmd(1'b0, 7'(7'h31 + k), 8'h00, 1'b0);
      @(negedge PCLK);
      n_cmp++;
      if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got cmd_ready=%0b after 4 pushes, required 0", cmd_ready); end
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 7'h35; cmd_wdata = 8'h00;
      for (int k = 0; k < 5; k++) begin
         @(negedge PCLK);
         if (cmd_ready !== 1'b0) bad = 1'b1;
      end
      n_cmp++;
      if (bad) begin n_err++; $display("FAIL full_hold: got cmd_ready=1 while stalled and full, required 0"); end
      cmd_valid = 1'b0;
      stall = 1'b0;
      push_cmd(1'b0, 7'h35, 8'h00, 1'b0);
      drain();
   endtask

   task automatic test_reset_mid();
      logic bad = 1'b0;
      wait_states = 0; stall = 1'b1;
      push_cmd(1'b1, 7'h4A, 8'hC3, 1'b0);
      push_cmd(1'b0, 7'h11, 8'h00, 1'b0);
      push_cmd(1'b0, 7'h12, 8'h00, 1'b0);
      @(negedge PCLK);
      n_cmp++;
      if (PENABLE !== 1'b1) begin n_err++; $display("FAIL rst_pre_access: got PENABLE=%0b, required 1", PENABLE); end
      exp_q.delete();
      PRESET = 1'b1;
      @(negedge PCLK);
      n_cmp++;
      if ({PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, cmd_ready} !== 19'h1) begin
         n_err++;
         $display("FAIL rst_mid: got sel=%0b en=%0b wr=%0b addr=%02h wdata=%02h rv=%0b rdy=%0b, required 0 0 0 00 00 0 1",
                  PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, cmd_ready);
      end
      PRESET = 1'b0;
      stall = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge PCLK);
         if (PSELx !== 1'b0) bad = 1'b1;
      end
      n_cmp++;
      if (bad) begin n_err++; $display("FAIL rst_discard: got PSELx=1 after reset, required queue discarded"); end
   endtask

`ifdef APB_TIMEOUT_EN
   task automatic test_timeout();
      int acc_n = 0, t = 0;
      logic got = 1'b0;
      wait_states = 0; stall = 1'b1;
      push_cmd(1'b0, 7'h44, 8'h00, 1'b1);
      push_cmd(1'b0, 7'h45, 8'h00, 1'b0);
      while (!got && t < 60) begin
         @(negedge PCLK);
         t++;
         if (PSELx && PENABLE) acc_n++;
         if (rsp_valid) begin got = 1'b1; stall = 1'b0; end
      end
      n_cmp++;
      if (!got || acc_n !== 16) begin
         n_err++;
         $display("FAIL tmo_len: got response=%0b after %0d ACCESS cycles, required 1 after 16", got, acc_n);
      end
      stall = 1'b0;
      drain();
   endtask
`endif

   initial begin
      PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 7'h00; cmd_wdata = 8'h00;
      test_reset();
      test_write_basic();
      test_read_wait();
      test_back_to_back();
      test_fifo_full();
      test_reset_mid();
`ifdef APB_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
